// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a byte-wide memory, with a one-entry read
// cache and a read timeout that shields requesters from the memory's missing-ready quirk.
module mem_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned TIMEOUT  = 8,
    parameter bit          CACHE_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read_en,
    output logic              mem_write_en,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int unsigned     CntW   = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StRdIssue, StRdWait} state_e;

    state_e            state_q;
    logic              last_grant_q;
    logic              gnt_q;
    logic [CntW-1:0]   cnt_q;
    logic              cache_valid_q;
    logic [ADDR_W-1:0] cache_addr_q;
    logic [DATA_W-1:0] cache_data_q;
    logic [1:0]        ack_q;
    logic [1:0]        err_q;
    logic [DATA_W-1:0] rdata_q [2];
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_read_en_q;
    logic              mem_write_en_q;

    logic              any_req;
    logic              sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              hit;

    // On a tie the port that did not win last time is chosen.
    always_comb begin
        any_req = p0_req | p1_req;
        if (p0_req && p1_req) begin
            sel = ~last_grant_q;
        end else begin
            sel = p1_req;
        end
        sel_we    = sel ? p1_we    : p0_we;
        sel_addr  = sel ? p1_addr  : p0_addr;
        sel_wdata = sel ? p1_wdata : p0_wdata;
        hit       = CACHE_EN && cache_valid_q && (cache_addr_q == sel_addr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            last_grant_q   <= 1'b1;
            gnt_q          <= 1'b0;
            cnt_q          <= '0;
            cache_valid_q  <= 1'b0;
            cache_addr_q   <= '0;
            cache_data_q   <= '0;
            ack_q          <= '0;
            err_q          <= '0;
            rdata_q[0]     <= '0;
            rdata_q[1]     <= '0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
        end else begin
            ack_q          <= '0;
            err_q          <= '0;
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (any_req) begin
                        last_grant_q <= sel;
                        gnt_q        <= sel;
                        if (sel_we) begin
                            mem_write_en_q <= 1'b1;
                            mem_addr_q     <= sel_addr;
                            mem_wdata_q    <= sel_wdata;
                            ack_q[sel]     <= 1'b1;
                            cache_valid_q  <= 1'b0;
                        end else if (hit) begin
                            ack_q[sel]   <= 1'b1;
                            rdata_q[sel] <= cache_data_q;
                        end else begin
                            mem_read_en_q <= 1'b1;
                            mem_addr_q    <= sel_addr;
                            state_q       <= StRdIssue;
                        end
                    end
                end
                StRdIssue: begin
                    state_q <= StRdWait;
                    cnt_q   <= '0;
                end
                StRdWait: begin
                    if (mem_ready) begin
                        rdata_q[gnt_q] <= mem_rdata;
                        cache_addr_q   <= mem_addr_q;
                        cache_data_q   <= mem_rdata;
                        cache_valid_q  <= 1'b1;
                        ack_q[gnt_q]   <= 1'b1;
                        state_q        <= StIdle;
                    end else if (cnt_q == CntMax) begin
                        // Memory will never answer (same-address lockout): give up.
                        rdata_q[gnt_q] <= '0;
                        cache_valid_q  <= 1'b0;
                        ack_q[gnt_q]   <= 1'b1;
                        err_q[gnt_q]   <= 1'b1;
                        state_q        <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign p0_ack       = ack_q[0];
    assign p1_ack       = ack_q[1];
    assign p0_err       = err_q[0];
    assign p1_err       = err_q[1];
    assign p0_rdata     = rdata_q[0];
    assign p1_rdata     = rdata_q[1];
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_read_en  = mem_read_en_q;
    assign mem_write_en = mem_write_en_q;

endmodule
